frame_loader: RTL and testbench

FRAME_LOADER -- requirements
Module: frame_loader

---
 rtl/frame_loader_pkg.sv | 37 +++
 rtl/frame_loader_if.sv | 24 ++
 rtl/frame_loader.sv | 92 +++++++++
 tb/tb_frame_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_loader_pkg.sv
// Shared frame geometry, FSM state encoding and address helpers for the frame loader.
package frame_loader_pkg;

    localparam int unsigned PANELS          = 4;
    localparam int unsigned ROWS            = 16;
    localparam int unsigned CHUNKS          = 16;
    localparam int unsigned WORDS_PER_FRAME = PANELS * ROWS * CHUNKS;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PANEL_W = $clog2(PANELS);
    localparam int unsigned ROW_W   = $clog2(ROWS);
    localparam int unsigned CHUNK_W = $clog2(CHUNKS);
    localparam int unsigned WORD_W  = $clog2(WORDS_PER_FRAME);

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_FRAME - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    typedef struct packed {
        logic [PANEL_W-1:0] panel;
        logic [ROW_W-1:0]   row;
        logic [CHUNK_W-1:0] chunk;
    } chunk_loc_t;

    // Word index to panel/row/chunk: chunk is the fastest-moving field.
    function automatic chunk_loc_t loc_of(input logic [WORD_W-1:0] w);
        chunk_loc_t loc;
        loc.chunk = w[CHUNK_W-1:0];
        loc.row   = w[CHUNK_W +: ROW_W];
        loc.panel = w[CHUNK_W+ROW_W +: PANEL_W];
        return loc;
    endfunction

endpackage

// File: rtl/frame_loader_if.sv
// Host word stream into the frame loader (valid/ready with start-of-frame marker).
interface frame_loader_if;
    import frame_loader_pkg::*;

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_sof;
    logic              s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_sof,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_sof,
        output s_ready
    );

endinterface

// File: rtl/frame_loader.sv
// Frame loader: scatters a 1024-word host stream into panel/row/chunk buffer writes,
// resynchronising on start-of-frame and flagging framing faults.
module frame_loader
    import frame_loader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    frame_loader_if.slave       s,
    input  logic                hold,
    output logic [DATA_W-1:0]   chunk_data,
    output logic [CHUNK_W-1:0]  chunk_addr,
    output logic [ROW_W-1:0]    row_data_row_addr,
    output logic [PANEL_W-1:0]  row_data_panel_addr,
    output logic                chunk_write_enable,
    output logic                frame_done,
    output logic                sync_error,
    input  logic                error_clear,
    output logic                busy
);

    state_t              state_q;
    logic [WORD_W-1:0]   w_q;
    logic [DATA_W-1:0]   data_q;
    chunk_loc_t          loc_q;
    logic                we_q;
    logic                done_q;
    logic                err_q;
    logic                busy_q;
    logic                xfer;

    // Ready depends only on backpressure and reset, never on loader state.
    assign s.s_ready = ~hold & ~reset;
    assign xfer      = s.s_valid & s.s_ready;

    // Frame FSM with word counter and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            w_q     <= '0;
            data_q  <= '0;
            loc_q   <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            // A fault flagged later in this block overrides the clear.
            if (error_clear) begin
                err_q <= 1'b0;
            end
            if (xfer) begin
                if (s.s_sof) begin
                    // Start of frame, or resync when it arrives mid-frame.
                    if (state_q == ST_LOAD) begin
                        err_q <= 1'b1;
                    end
                    data_q  <= s.s_data;
                    loc_q   <= '0;
                    we_q    <= 1'b1;
                    w_q     <= WORD_W'(1);
                    state_q <= ST_LOAD;
                    busy_q  <= 1'b1;
                end else if (state_q == ST_LOAD) begin
                    data_q <= s.s_data;
                    loc_q  <= loc_of(w_q);
                    we_q   <= 1'b1;
                    if (w_q == LAST_WORD) begin
                        w_q     <= '0;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        w_q <= w_q + 1'b1;
                    end
                end
                // Words without sof while idle are consumed and dropped.
            end
        end
    end

    assign chunk_data          = data_q;
    assign chunk_addr          = loc_q.chunk;
    assign row_data_row_addr   = loc_q.row;
    assign row_data_panel_addr = loc_q.panel;
    assign chunk_write_enable  = we_q;
    assign frame_done          = done_q;
    assign sync_error          = err_q;
    assign busy                = busy_q;

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader: short vector table plus full-frame sequences.
module tb_frame_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic        error_clear;
    logic [31:0] chunk_data;
    logic [3:0]  chunk_addr;
    logic [3:0]  row_addr;
    logic [1:0]  panel_addr;
    logic        we;
    logic        done;
    logic        err;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    frame_loader_if bus ();

    frame_loader dut (
        .clk                 (clk),
        .reset               (reset),
        .s                   (bus.slave),
        .hold                (hold),
        .chunk_data          (chunk_data),
        .chunk_addr          (chunk_addr),
        .row_data_row_addr   (row_addr),
        .row_data_panel_addr (panel_addr),
        .chunk_write_enable  (we),
        .frame_done          (done),
        .sync_error          (err),
        .error_clear         (error_clear),
        .busy                (busy)
    );

    typedef struct {
        logic        valid;
        logic        sof;
        logic        hold;
        logic        clr;
        logic [31:0] data;
        logic        e_ready;
        logic        e_we;
        logic        e_done;
        logic        e_err;
        logic        e_busy;
        logic [31:0] e_data;
        logic [9:0]  e_addr;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cur_addr();
        return 32'({panel_addr, row_addr, chunk_addr});
    endfunction

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_data  = '0;
        hold        = 1'b0;
        error_clear = 1'b0;
    endtask

    task automatic xfer(input logic [31:0] d, input logic sof, input logic [9:0] ea,
                        input logic ed, input logic ee);
        bus.s_data  = d;
        bus.s_sof   = sof;
        bus.s_valid = 1'b1;
        hold        = 1'b0;
        step();
        check("xfer_we",   32'(we),   32'd1);
        check("xfer_addr", cur_addr(), 32'(ea));
        check("xfer_data", chunk_data, d);
        check("xfer_done", 32'(done), 32'(ed));
        check("xfer_err",  32'(err),  32'(ee));
        check("xfer_busy", 32'(busy), 32'(!ed));
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b1;
        #1;
        check("rst_ready", 32'(bus.s_ready), 32'd0);
        step();
        step();
        check("rst_we",   32'(we),   32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err",  32'(err),  32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", chunk_data, 32'd0);
        check("rst_addr", cur_addr(), 32'd0);
        reset = 1'b0;
    endtask

    task automatic full_frame(input logic [31:0] base);
        for (int i = 0; i < 1024; i++) begin
            xfer(base + 32'(i), (i == 0), 10'(i), (i == 1023), 1'b0);
        end
        step();
        check("post_frame_we",   32'(we),   32'd0);
        check("post_frame_done", 32'(done), 32'd0);
        check("post_frame_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        quiet();
        reset = 1'b1;
        //             vld sof hld clr data          rdy we  dn  er  by  e_data        e_addr
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h000000AA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   10'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h000000BB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   10'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00000100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 10'd0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h101, 10'd1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00000102, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h101, 10'd1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000102, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h102, 10'd2};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h00000200, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 10'd0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 10'd0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000201, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h201, 10'd1};

        #1;
        do_reset();

        // Vector table: garbage, ignored sof, start, hold, resync with clear, clear.
        for (int i = 0; i < 9; i++) begin
            bus.s_valid = vecs[i].valid;
            bus.s_sof   = vecs[i].sof;
            bus.s_data  = vecs[i].data;
            hold        = vecs[i].hold;
            error_clear = vecs[i].clr;
            #1;
            check($sformatf("vec%0d_ready", i), 32'(bus.s_ready), 32'(vecs[i].e_ready));
            step();
            check($sformatf("vec%0d_we",   i), 32'(we),   32'(vecs[i].e_we));
            check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
            check($sformatf("vec%0d_err",  i), 32'(err),  32'(vecs[i].e_err));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_data", i), chunk_data, vecs[i].e_data);
            check($sformatf("vec%0d_addr", i), cur_addr(), 32'(vecs[i].e_addr));
        end

        // Clean full frame, data = index; last word at panel 3 row 15 chunk 15.
        do_reset();
        full_frame(32'd0);
        check("last_panel", 32'(panel_addr), 32'd3);
        check("last_row",   32'(row_addr),   32'd15);
        check("last_chunk", 32'(chunk_addr), 32'd15);

        // Backpressure at word 300.
        for (int i = 0; i < 300; i++) xfer(32'(i), (i == 0), 10'(i), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 32'd300;
            hold        = 1'b1;
            #1;
            check("hold_ready", 32'(bus.s_ready), 32'd0);
            step();
            check("hold_we", 32'(we), 32'd0);
        end
        xfer(32'd300, 1'b0, 10'd300, 1'b0, 1'b0);
        check("bp_panel", 32'(panel_addr), 32'd1);
        check("bp_row",   32'(row_addr),   32'd2);
        check("bp_chunk", 32'(chunk_addr), 32'd12);
        for (int i = 301; i < 1024; i++) xfer(32'(i), 1'b0, 10'(i), (i == 1023), 1'b0);

        // Resync: sof again at word 500, then 1024 words from the resync word.
        for (int i = 0; i < 500; i++) xfer(32'(i), (i == 0), 10'(i), 1'b0, 1'b0);
        xfer(32'hABC0_0500, 1'b1, 10'd0, 1'b0, 1'b1);
        for (int k = 1; k < 1024; k++) xfer(32'hABC0_0500 + 32'(k), 1'b0, 10'(k), (k == 1023), 1'b1);
        error_clear = 1'b1;
        step();
        error_clear = 1'b0;
        check("clr_err", 32'(err), 32'd0);
        check("clr_we",  32'(we),  32'd0);

        // Reset mid-frame at word 700.
        for (int i = 0; i < 700; i++) xfer(32'(i), (i == 0), 10'(i), 1'b0, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data  = 32'd700;
        reset       = 1'b1;
        #1;
        check("midrst_ready", 32'(bus.s_ready), 32'd0);
        step();
        check("midrst_we",   32'(we),   32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_err",  32'(err),  32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_data", chunk_data, 32'd0);
        check("midrst_addr", cur_addr(), 32'd0);
        reset      = 1'b0;
        bus.s_data = 32'd701;
        step();
        check("after_rst_we",   32'(we),   32'd0);
        check("after_rst_busy", 32'(busy), 32'd0);
        quiet();
        full_frame(32'h5000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
